// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the fetch sequencing logic.
//   fetch_state_t      - fetch controller state encoding (BOOT/RUN/HALT/FAULT)
//   FETCH_RESET_VECTOR - default PC loaded on reset
//   is_word_aligned    - true when a byte address sits on a 32-bit boundary
package pipeline_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] FETCH_RESET_VECTOR = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [1:0] byte_lsb);
    return (byte_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundle between hazard unit / EX stage / IF stage and the
// fetch controller.
//   master modport (pipeline side): drives StallF, PCSrcE, PCTargetE, PCPlus4F,
//     halt_req, resume; observes PCF, fetch_valid, fault, fault_pc,
//     fetch_state, fetch_count.
//   slave modport (fetch_ctrl): the mirror image.
interface fetch_ctrl_if #(
  parameter int XLEN = 32
);
  import pipeline_pkg::*;

  // Requests into the controller
  logic            StallF;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic [XLEN-1:0] PCPlus4F;
  logic            halt_req;
  logic            resume;

  // Controller outputs (all registered)
  logic [XLEN-1:0] PCF;
  logic            fetch_valid;
  logic            fault;
  logic [XLEN-1:0] fault_pc;
  fetch_state_t    fetch_state;
  logic [XLEN-1:0] fetch_count;

  modport master (
    output StallF, PCSrcE, PCTargetE, PCPlus4F, halt_req, resume,
    input  PCF, fetch_valid, fault, fault_pc, fetch_state, fetch_count
  );

  modport slave (
    input  StallF, PCSrcE, PCTargetE, PCPlus4F, halt_req, resume,
    output PCF, fetch_valid, fault, fault_pc, fetch_state, fetch_count
  );

endinterface

// File: rtl/fetch_fault_check.sv
// fetch_fault_check: combinational legality check on the candidate next PC.
//   cand_pc      in  XLEN : redirect target or sequential PC under consideration
//   redirect     in  1    : cand_pc is a redirect target (alignment applies)
//   misaligned   out 1    : redirect target not word aligned
//   out_of_range out 1    : cand_pc at or beyond MEMORY_CAPACITY*4 bytes
// Optional feature macro: FETCH_BOUNDS_CHECK_EN enables the range comparison;
// without it out_of_range is tied low and imem wraps addresses by index.
module fetch_fault_check
  import pipeline_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int MEMORY_CAPACITY = 256
) (
  input  logic [XLEN-1:0] cand_pc,
  input  logic            redirect,
  output logic            misaligned,
  output logic            out_of_range
);

  // Sequential PCs come from PCPlus4F and are trusted to stay aligned.
  assign misaligned = redirect && !is_word_aligned(cand_pc[1:0]);

`ifdef FETCH_BOUNDS_CHECK_EN
  // One extra bit so the byte bound itself never wraps at full XLEN.
  localparam logic [XLEN:0] BYTE_BOUND = (XLEN+1)'(MEMORY_CAPACITY) << 2;

  assign out_of_range = ({1'b0, cand_pc} >= BYTE_BOUND);
`else
  localparam int unused_capacity = MEMORY_CAPACITY;
  logic unused_upper_bits;

  assign unused_upper_bits = &{1'b0, cand_pc[XLEN-1:2]};
  assign out_of_range      = 1'b0;
`endif

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencing controller. Owns the PC register,
// chooses the next PC (redirect > stall > halt > sequential) and gates fetch
// validity through a BOOT/RUN/HALT/FAULT state machine.
//   clk   in 1 : rising-edge clock
//   reset in 1 : asynchronous active-high reset
//   bus   slave modport of fetch_ctrl_if:
//     in : StallF, PCSrcE, PCTargetE, PCPlus4F, halt_req, resume
//     out: PCF, fetch_valid, fault, fault_pc, fetch_state, fetch_count
// Optional feature macro: FETCH_BOUNDS_CHECK_EN (range fault on next PC,
// implemented inside fetch_fault_check).
module fetch_ctrl
  import pipeline_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter int              MEMORY_CAPACITY = 256,
  parameter logic [XLEN-1:0] RESET_VECTOR    = XLEN'(FETCH_RESET_VECTOR)
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.slave  bus
);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            fault_reg, fault_next;
  logic [XLEN-1:0] fault_pc_reg, fault_pc_next;
  logic [XLEN-1:0] count_reg, count_next;

  logic            fetch_valid;
  logic            count_en;
  logic [XLEN-1:0] cand_pc;
  logic            misaligned;
  logic            out_of_range;
  logic            cand_bad;

  // Only one candidate can be taken per cycle, so one checker suffices.
  assign cand_pc = bus.PCSrcE ? bus.PCTargetE : bus.PCPlus4F;

  fetch_fault_check #(
    .XLEN            (XLEN),
    .MEMORY_CAPACITY (MEMORY_CAPACITY)
  ) u_fault_check (
    .cand_pc      (cand_pc),
    .redirect     (bus.PCSrcE),
    .misaligned   (misaligned),
    .out_of_range (out_of_range)
  );

  assign cand_bad = misaligned | out_of_range;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg       <= RESET_VECTOR;
      fault_reg    <= 1'b0;
      fault_pc_reg <= '0;
      count_reg    <= '0;
    end else begin
      pc_reg       <= pc_next;
      fault_reg    <= fault_next;
      fault_pc_reg <= fault_pc_next;
      count_reg    <= count_next;
    end
  end

  // Next state and next PC
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    fault_next    = fault_reg;
    fault_pc_next = fault_pc_reg;

    case (state_reg)
      BOOT: begin
        state_next = RUN;
      end

      RUN: begin
        if (bus.PCSrcE) begin
          if (cand_bad) begin
            state_next    = FAULT;
            fault_next    = 1'b1;
            fault_pc_next = bus.PCTargetE;
          end else begin
            pc_next = bus.PCTargetE;
            // A branch resolving in the halt cycle is not lost.
            if (bus.halt_req) begin
              state_next = HALT;
            end
          end
        end else if (bus.StallF) begin
          pc_next = pc_reg;
        end else if (bus.halt_req) begin
          state_next = HALT;
        end else if (cand_bad) begin
          state_next    = FAULT;
          fault_next    = 1'b1;
          fault_pc_next = bus.PCPlus4F;
        end else begin
          pc_next = bus.PCPlus4F;
        end
      end

      HALT: begin
        if (bus.PCSrcE && cand_bad) begin
          state_next    = FAULT;
          fault_next    = 1'b1;
          fault_pc_next = bus.PCTargetE;
        end else begin
          if (bus.PCSrcE) begin
            pc_next = bus.PCTargetE;
          end
          // resume outranks a simultaneous halt_req, which is a no-op here.
          if (bus.resume) begin
            state_next = RUN;
          end
        end
      end

      default: begin
        // FAULT absorbs everything until reset.
        state_next = FAULT;
      end
    endcase
  end

  // State-decoded outputs and fetch counter
  always_comb begin
    fetch_valid = (state_reg == RUN);
    count_en    = fetch_valid && !bus.StallF && !bus.PCSrcE;
    count_next  = count_reg + XLEN'(count_en);
  end

  assign bus.PCF         = pc_reg;
  assign bus.fetch_valid = fetch_valid;
  assign bus.fault       = fault_reg;
  assign bus.fault_pc    = fault_pc_reg;
  assign bus.fetch_state = state_reg;
  assign bus.fetch_count = count_reg;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch stage. Owns the PC register and feeds `PCF` to the IF stage. Selects the next PC from reset, EX-stage redirect, stall hold or sequential `PCPlus4F`, and gates fetch validity through a small boot/run/halt/fault state machine. Sits between the hazard unit / EX stage and the IF stage in the 5-stage pipeline.

## Interface
Parameters:
- `XLEN`, 32, datapath and PC width.
- `MEMORY_CAPACITY`, 256, instruction memory size in 32-bit words; byte bound = `MEMORY_CAPACITY*4`.
- `RESET_VECTOR`, 32'h0, PC loaded on reset.

Ports:
- `clk` in 1: the single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high.
- `StallF` in 1: hazard-unit stall; hold PC.
- `PCSrcE` in 1: redirect request from EX.
- `PCTargetE` in XLEN: redirect target.
- `PCPlus4F` in XLEN: sequential next PC from IF stage.
- `halt_req` in 1: request to stop fetching.
- `resume` in 1: leave HALT.
- `PCF` out XLEN: current fetch PC.
- `fetch_valid` out 1: `PCF` carries a real fetch this cycle.
- `fault` out 1: sticky fetch fault.
- `fault_pc` out XLEN: offending target/PC captured on fault.
- `fetch_state` out 2: current FSM state, `fetch_state_t` encoding.
- `fetch_count` out XLEN: count of accepted fetches.

## Operation
- Reset values: state BOOT, `PCF`=RESET_VECTOR, `fetch_valid`=0, `fault`=0, `fault_pc`=0, `fetch_count`=0.
- States: BOOT=0, RUN=1, HALT=2, FAULT=3.
- `fetch_valid` is 1 only in RUN.
- BOOT:
  - Holds PC for exactly one cycle, then goes to RUN.
  - Inputs are ignored.
- RUN next-PC priority:
  1. `PCSrcE`: load `PCTargetE`. This wins over `StallF` and `halt_req`.
  2. `StallF`: hold PC.
  3. `halt_req`: hold PC and go to HALT.
  4. Otherwise: load `PCPlus4F`.
- Redirect with `halt_req` in the same cycle: PC loads the target and the state still goes to HALT.
- HALT:
  - PC is held.
  - A redirect still loads `PCTargetE`, so no pending branch is lost; the state stays HALT.
  - `resume`=1 goes to RUN next cycle.
  - `halt_req` and `resume` together: `resume` wins.
- Alignment check (always present): a redirect with `PCTargetE[1:0]`≠0 does not update PC. Instead:
  - state goes to FAULT;
  - `fault` is set;
  - `fault_pc` captures `PCTargetE`.
- FAULT:
  - Absorbing until `reset`.
  - PC held, `fetch_valid`=0.
  - All inputs are ignored.
- `fetch_count`:
  - Increments by 1 in each cycle with `fetch_valid`=1, `StallF`=0 and `PCSrcE`=0.
  - Wraps modulo 2^XLEN.
- Arithmetic: the block performs no PC arithmetic. `PCPlus4F` is taken as given, and wrap is inherited.

## Timing
- Registered outputs; zero combinational paths from inputs to outputs.
- Redirect asserted in cycle n: `PCF`=target in cycle n+1.
- `halt_req` in cycle n: `fetch_valid`=0 from cycle n+1.
- `resume` in cycle n: `fetch_valid`=1 from n+1, fetching from the held PC.
- First valid fetch after reset release: second rising edge (one BOOT cycle).
- Reset asserted mid-operation: immediate asynchronous return to all reset values, including clearing FAULT.

## Configuration
- Macro `FETCH_BOUNDS_CHECK_EN`.
- Defined: any candidate next PC ≥ `MEMORY_CAPACITY*4` enters FAULT. Candidates are the redirect target or `PCPlus4F`. On entry:
  - PC is not updated;
  - `fault_pc` captures the candidate.
- Alignment fault takes precedence when both checks fail.
- Undefined: no bounds check; out-of-range PCs are passed to imem unchecked, and imem wraps by index.

## Structure
- `pipeline_pkg` gains:
  - `fetch_state_t`, a 2-bit enum: BOOT, RUN, HALT, FAULT;
  - constant `FETCH_RESET_VECTOR`, used as the default for `RESET_VECTOR`.
- One sub-module, `fetch_fault_check` (combinational). Inputs: candidate PC, redirect flag. Outputs: `misaligned`, `out_of_range`. The range logic sits under the macro.

## Test plan
- Reset, then 4 idle cycles with `RESET_VECTOR`=0:
  - `PCF` = 0 during BOOT, then 0,4,8 in RUN;
  - `fetch_valid` = 0,1,1,1;
  - `fetch_count` = 3.
- In RUN at `PCF`=8, `PCSrcE`=1 with `PCTargetE`=0x40 and `StallF`=1 together → `PCF`=0x40 next cycle; count not incremented in that cycle.
- `halt_req` at `PCF`=0x10 → `fetch_valid`=0 and `PCF` held at 0x10. Then redirect to 0x80 while halted → `PCF`=0x80 and state HALT. Then `resume` → RUN with `fetch_valid`=1 at 0x80.
- Redirect to 0x42 → FAULT, `fault`=1, `fault_pc`=0x42, `PCF` unchanged. Further inputs ignored. Assert `reset` mid-FAULT → all outputs return to reset values.
- With `FETCH_BOUNDS_CHECK_EN`, `MEMORY_CAPACITY`=256, running sequentially to `PCF`=0x3FC → next candidate 0x400 faults with `fault_pc`=0x400. Without the macro: `PCF`=0x400 and `fetch_valid`=1.
